upc_checkout_ctrl: RTL and testbench

- Sequential, parametrised successor to the combinational UPC marker/display pair.
- Samples a UPC code and a "marked" bit on each rising edge of a scan request. Classifies the item as discounted and/or expensive using parameter masks.
- Maintains saturating item, discount and theft counters. Latches a theft alarm that needs a minimum hold time and an explicit clear.
- Sits between the board switches/KEY inputs and the LEDR/HEX drivers in the top level.

---
 rtl/upc_checkout_ctrl.sv | 152 +++++++++++++++
 tb/tb_upc_checkout_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/upc_checkout_ctrl.sv
// Checkout controller: samples a UPC code on each scan rise, classifies it,
// keeps saturating item/discount/theft counters and a sticky theft alarm.
module upc_checkout_ctrl #(
    parameter int                   UPC_W      = 3,
    parameter logic [2**UPC_W-1:0]  DISC_MASK  = 8'b1000_1010,
    parameter logic [2**UPC_W-1:0]  EXP_MASK   = 8'b0010_1001,
    parameter int                   CNT_W      = 8,
    parameter int                   ALARM_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan,
    input  logic [UPC_W-1:0] upc,
    input  logic             mark,
    input  logic             clear,
    output logic             discount,
    output logic             alarm,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] disc_count,
    output logic [CNT_W-1:0] theft_count,
    output logic [UPC_W-1:0] last_upc,
    output logic             last_valid,
    output logic             busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CLASSIFY = 2'd1;
    localparam logic [1:0] ALARM    = 2'd2;

    localparam int               HOLD_W    = $clog2(ALARM_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ALARM_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic              scan_q;
    logic [UPC_W-1:0]  cap_upc_q, cap_upc_d;
    logic              cap_mark_q, cap_mark_d;
    logic              discount_q, discount_d;
    logic              alarm_q, alarm_d;
    logic [CNT_W-1:0]  item_count_q, item_count_d;
    logic [CNT_W-1:0]  disc_count_q, disc_count_d;
    logic [CNT_W-1:0]  theft_count_q, theft_count_d;
    logic [UPC_W-1:0]  last_upc_q, last_upc_d;
    logic              last_valid_q, last_valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic rise;
    logic d_bit;
    logic t_bit;

    always_comb begin
        rise  = scan & ~scan_q;
        d_bit = DISC_MASK[cap_upc_q];
        t_bit = EXP_MASK[cap_upc_q] & ~cap_mark_q;

        state_d       = state_q;
        cap_upc_d     = cap_upc_q;
        cap_mark_d    = cap_mark_q;
        discount_d    = discount_q;
        alarm_d       = alarm_q;
        item_count_d  = item_count_q;
        disc_count_d  = disc_count_q;
        theft_count_d = theft_count_q;
        last_upc_d    = last_upc_q;
        last_valid_d  = last_valid_q;
        hold_d        = hold_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    cap_upc_d  = upc;
                    cap_mark_d = mark;
                    state_d    = CLASSIFY;
                end
            end
            CLASSIFY: begin
                last_upc_d   = cap_upc_q;
                last_valid_d = 1'b1;
                discount_d   = d_bit;
                if (item_count_q != CNT_MAX) begin
                    item_count_d = item_count_q + 1'b1;
                end
                if (d_bit && (disc_count_q != CNT_MAX)) begin
                    disc_count_d = disc_count_q + 1'b1;
                end
                if (t_bit) begin
                    if (theft_count_q != CNT_MAX) begin
                        theft_count_d = theft_count_q + 1'b1;
                    end
                    alarm_d = 1'b1;
                    hold_d  = HOLD_INIT;
                    state_d = ALARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ALARM: begin
                // Clear is only honoured once the hold time has fully elapsed.
                alarm_d = 1'b1;
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (clear) begin
                    alarm_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            scan_q        <= 1'b0;
            cap_upc_q     <= '0;
            cap_mark_q    <= 1'b0;
            discount_q    <= 1'b0;
            alarm_q       <= 1'b0;
            item_count_q  <= '0;
            disc_count_q  <= '0;
            theft_count_q <= '0;
            last_upc_q    <= '0;
            last_valid_q  <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            scan_q        <= scan;
            cap_upc_q     <= cap_upc_d;
            cap_mark_q    <= cap_mark_d;
            discount_q    <= discount_d;
            alarm_q       <= alarm_d;
            item_count_q  <= item_count_d;
            disc_count_q  <= disc_count_d;
            theft_count_q <= theft_count_d;
            last_upc_q    <= last_upc_d;
            last_valid_q  <= last_valid_d;
            hold_q        <= hold_d;
        end
    end

    assign discount    = discount_q;
    assign alarm       = alarm_q;
    assign item_count  = item_count_q;
    assign disc_count  = disc_count_q;
    assign theft_count = theft_count_q;
    assign last_upc    = last_upc_q;
    assign last_valid  = last_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Directed bench for upc_checkout_ctrl: table-driven code sweep plus
// hand-written alarm-hold, ignored-scan, saturation and async-reset sequences.
module tb_upc_checkout_ctrl;

    localparam int ALARM_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       scan = 1'b0;
    logic [2:0] upc = 3'd0;
    logic       mark = 1'b0;
    logic       clear = 1'b0;

    logic       discount, alarm, last_valid, busy;
    logic [7:0] item_count, disc_count, theft_count;
    logic [2:0] last_upc;

    logic       s_discount, s_alarm, s_last_valid, s_busy;
    logic [1:0] s_item_count, s_disc_count, s_theft_count;
    logic [2:0] s_last_upc;

    int pass_count = 0;
    int check_count = 0;

    typedef struct {
        logic [2:0] upc;
        logic       mark;
        logic       exp_disc;
        logic       exp_alarm;
        int         exp_item;
        int         exp_dcnt;
        int         exp_theft;
    } vec_t;

    vec_t vecs[16];

    upc_checkout_ctrl #(.CNT_W(8), .ALARM_HOLD(ALARM_HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .scan(scan), .upc(upc), .mark(mark),
        .clear(clear), .discount(discount), .alarm(alarm),
        .item_count(item_count), .disc_count(disc_count),
        .theft_count(theft_count), .last_upc(last_upc),
        .last_valid(last_valid), .busy(busy)
    );

    upc_checkout_ctrl #(.CNT_W(2), .ALARM_HOLD(ALARM_HOLD)) dut_sat (
        .clk(clk), .reset_n(reset_n), .scan(scan), .upc(upc), .mark(mark),
        .clear(clear), .discount(s_discount), .alarm(s_alarm),
        .item_count(s_item_count), .disc_count(s_disc_count),
        .theft_count(s_theft_count), .last_upc(s_last_upc),
        .last_valid(s_last_valid), .busy(s_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        check_count++;
        if (act == exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Rise in one cycle, drop it, outputs settle after the second edge.
    task automatic applyStimulus(input logic [2:0] in_upc, input logic in_mark);
        scan = 1'b1;
        upc  = in_upc;
        mark = in_mark;
        tick();
        scan = 1'b0;
        tick();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        scan = 1'b0;
        clear = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic clearAlarm(input string name);
        int cycles;
        cycles = 0;
        clear = 1'b1;
        while (alarm && cycles < 20) begin
            tick();
            cycles++;
        end
        clear = 1'b0;
        checkOutput({name, "_hold_cycles"}, cycles, ALARM_HOLD + 1);
        checkOutput({name, "_alarm_cleared"}, alarm, 0);
        checkOutput({name, "_busy_cleared"}, busy, 0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b1,  1, 0, 1};
        vecs[1]  = '{3'd0, 1'b1, 1'b0, 1'b0,  2, 0, 1};
        vecs[2]  = '{3'd1, 1'b0, 1'b1, 1'b0,  3, 1, 1};
        vecs[3]  = '{3'd1, 1'b1, 1'b1, 1'b0,  4, 2, 1};
        vecs[4]  = '{3'd2, 1'b0, 1'b0, 1'b0,  5, 2, 1};
        vecs[5]  = '{3'd2, 1'b1, 1'b0, 1'b0,  6, 2, 1};
        vecs[6]  = '{3'd3, 1'b0, 1'b1, 1'b1,  7, 3, 2};
        vecs[7]  = '{3'd3, 1'b1, 1'b1, 1'b0,  8, 4, 2};
        vecs[8]  = '{3'd4, 1'b0, 1'b0, 1'b0,  9, 4, 2};
        vecs[9]  = '{3'd4, 1'b1, 1'b0, 1'b0, 10, 4, 2};
        vecs[10] = '{3'd5, 1'b0, 1'b0, 1'b1, 11, 4, 3};
        vecs[11] = '{3'd5, 1'b1, 1'b0, 1'b0, 12, 4, 3};
        vecs[12] = '{3'd6, 1'b0, 1'b0, 1'b0, 13, 4, 3};
        vecs[13] = '{3'd6, 1'b1, 1'b0, 1'b0, 14, 4, 3};
        vecs[14] = '{3'd7, 1'b0, 1'b1, 1'b0, 15, 5, 3};
        vecs[15] = '{3'd7, 1'b1, 1'b1, 1'b0, 16, 6, 3};

        #2;
        doReset();
        checkOutput("rst_item", item_count, 0);
        checkOutput("rst_disc", disc_count, 0);
        checkOutput("rst_theft", theft_count, 0);
        checkOutput("rst_alarm", alarm, 0);
        checkOutput("rst_discount", discount, 0);
        checkOutput("rst_last_valid", last_valid, 0);
        checkOutput("rst_busy", busy, 0);

        // First scan, with a look at the intermediate CLASSIFY cycle.
        scan = 1'b1; upc = 3'd1; mark = 1'b0;
        tick();
        scan = 1'b0;
        checkOutput("t1_busy_classify", busy, 1);
        checkOutput("t1_item_not_yet", item_count, 0);
        tick();
        checkOutput("t1_discount", discount, 1);
        checkOutput("t1_item", item_count, 1);
        checkOutput("t1_disc", disc_count, 1);
        checkOutput("t1_alarm", alarm, 0);
        checkOutput("t1_last_upc", last_upc, 1);
        checkOutput("t1_last_valid", last_valid, 1);
        checkOutput("t1_busy", busy, 0);

        // Theft with an early clear that must be ignored.
        applyStimulus(3'd0, 1'b0);
        checkOutput("t2_alarm", alarm, 1);
        checkOutput("t2_theft", theft_count, 1);
        checkOutput("t2_busy", busy, 1);
        checkOutput("t2_discount", discount, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        checkOutput("t2_early_clear_ignored", alarm, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("t2_alarm_cleared", alarm, 0);
        checkOutput("t2_busy_idle", busy, 0);

        // Scans during ALARM are ignored.
        applyStimulus(3'd5, 1'b0);
        checkOutput("t3_alarm", alarm, 1);
        checkOutput("t3_item_before", item_count, 3);
        for (int k = 0; k < 3; k++) begin
            scan = 1'b1; upc = 3'd3; mark = 1'b0;
            tick();
            scan = 1'b0;
            tick();
        end
        checkOutput("t3_item_unchanged", item_count, 3);
        checkOutput("t3_disc_unchanged", disc_count, 1);
        checkOutput("t3_theft_unchanged", theft_count, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("t3_cleared", alarm, 0);
        applyStimulus(3'd3, 1'b1);
        checkOutput("t3_item_after", item_count, 4);
        checkOutput("t3_disc_after", disc_count, 2);
        checkOutput("t3_discount_after", discount, 1);
        checkOutput("t3_last_upc", last_upc, 3);

        // Scan held high counts once.
        scan = 1'b1; upc = 3'd2; mark = 1'b0;
        repeat (20) tick();
        scan = 1'b0;
        repeat (2) tick();
        checkOutput("t5_item_once", item_count, 5);
        checkOutput("t5_disc", disc_count, 2);
        checkOutput("t5_last_upc", last_upc, 2);
        checkOutput("t5_busy", busy, 0);

        // Full {upc, mark} sweep from reset.
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].upc, vecs[i].mark);
            checkOutput($sformatf("sw%0d_discount", i), discount, vecs[i].exp_disc);
            checkOutput($sformatf("sw%0d_alarm", i), alarm, vecs[i].exp_alarm);
            checkOutput($sformatf("sw%0d_item", i), item_count, vecs[i].exp_item);
            checkOutput($sformatf("sw%0d_disc", i), disc_count, vecs[i].exp_dcnt);
            checkOutput($sformatf("sw%0d_theft", i), theft_count, vecs[i].exp_theft);
            checkOutput($sformatf("sw%0d_last_upc", i), last_upc, vecs[i].upc);
            if (vecs[i].exp_alarm) begin
                clearAlarm($sformatf("sw%0d", i));
            end
        end

        // Saturation on the narrow instance, then reset inside CLASSIFY.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'd1, 1'b0);
        end
        checkOutput("t6_sat_item", s_item_count, 3);
        checkOutput("t6_sat_disc", s_disc_count, 3);
        checkOutput("t6_sat_theft", s_theft_count, 0);
        checkOutput("t6_wide_item", item_count, 5);
        checkOutput("t6_wide_disc", disc_count, 5);
        scan = 1'b1; upc = 3'd7; mark = 1'b0;
        tick();
        checkOutput("t6_busy_classify", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_item", item_count, 0);
        checkOutput("t6_async_disc", disc_count, 0);
        checkOutput("t6_async_discount", discount, 0);
        checkOutput("t6_async_last_valid", last_valid, 0);
        checkOutput("t6_async_last_upc", last_upc, 0);
        checkOutput("t6_async_busy", busy, 0);
        checkOutput("t6_async_sat_item", s_item_count, 0);
        checkOutput("t6_async_sat_disc", s_disc_count, 0);
        scan = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        checkOutput("t6_post_item", item_count, 0);
        checkOutput("t6_post_busy", busy, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
